// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums blocks of signed products arriving over a valid/ready
//               handshake and presents each block sum, its product count and
//               a sticky signed-overflow flag over a second valid/ready
//               handshake. A block closes after BLK_LEN products or early on
//               flush (when it holds, or is receiving, at least one product).
//
// Ports       : clk        - single clock, rising edge
//               reset      - asynchronous, active-high reset
//               src_valid  - product available
//               src_ready  - accumulator can take a product (ACC state)
//               src_data   - signed product, PROD_W bits
//               flush      - close the current partial block
//               dest_valid - block result available (HOLD state)
//               dest_ready - consumer takes the result
//               dest_data  - signed block sum, ACC_W bits
//               dest_count - number of products in the sum
//               dest_ovf   - signed overflow occurred within the block
//
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator #(
    parameter int PROD_W  = 32,
    parameter int ACC_W   = 40,
    parameter int BLK_LEN = 8,
    parameter int CNT_W   = $clog2(BLK_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [PROD_W-1:0] src_data,
    input  logic              flush,
    output logic              dest_valid,
    input  logic              dest_ready,
    output logic [ACC_W-1:0]  dest_data,
    output logic [CNT_W-1:0]  dest_count,
    output logic              dest_ovf
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_st_acc  = 1'b0;
    localparam logic [0:0] c_st_hold = 1'b1;

    // Count value at which the next accept completes a full block.
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(BLK_LEN - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic [ACC_W-1:0] r_dest_data;
    logic [CNT_W-1:0] r_dest_count;
    logic             r_dest_ovf;

    logic             w_in_acc;
    logic             w_accept;
    logic [ACC_W-1:0] w_src_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_add_ovf;
    logic [ACC_W-1:0] w_acc_upd;
    logic [CNT_W-1:0] w_cnt_upd;
    logic             w_ovf_upd;
    logic             w_full_close;
    logic             w_flush_close;
    logic             w_close;

    // ------------------------------------------------------------------------
    // Datapath combinational logic
    // ------------------------------------------------------------------------
    assign w_in_acc  = (r_state == c_st_acc);
    assign w_accept  = src_valid && w_in_acc;

    // Sign-extend the product to the accumulator width; the add wraps
    // modulo 2^ACC_W.
    assign w_src_ext = ACC_W'($signed(src_data));
    assign w_sum     = r_acc + w_src_ext;

    // Signed overflow: operands share a sign but the result does not.
    assign w_add_ovf = (r_acc[ACC_W-1] == w_src_ext[ACC_W-1]) &&
                       (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    // Values the block would hold after this cycle's (optional) accept.
    assign w_acc_upd = w_accept ? w_sum : r_acc;
    assign w_cnt_upd = w_accept ? (r_cnt + CNT_W'(1)) : r_cnt;
    assign w_ovf_upd = r_ovf || (w_accept && w_add_ovf);

    // An empty block with no accept this cycle ignores flush.
    assign w_full_close  = w_accept && (r_cnt == c_last_cnt);
    assign w_flush_close = w_in_acc && flush && ((r_cnt != '0) || w_accept);
    assign w_close       = w_full_close || w_flush_close;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_acc;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_acc: begin
                if (w_close) begin
                    w_state_next = c_st_hold;
                end
            end
            c_st_hold: begin
                if (dest_ready) begin
                    w_state_next = c_st_acc;
                end
            end
            default: begin
                w_state_next = c_st_acc;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs, decoded from the state only
    // ------------------------------------------------------------------------
    always_comb begin
        src_ready  = 1'b0;
        dest_valid = 1'b0;
        case (r_state)
            c_st_acc:  src_ready  = 1'b1;
            c_st_hold: dest_valid = 1'b1;
            default:   src_ready  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Accumulator and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_dest_data  <= '0;
            r_dest_count <= '0;
            r_dest_ovf   <= 1'b0;
        end else if (w_close) begin
            // Capture the finished block and start the next one empty.
            r_dest_data  <= w_acc_upd;
            r_dest_count <= w_cnt_upd;
            r_dest_ovf   <= w_ovf_upd;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_upd;
            r_cnt <= w_cnt_upd;
            r_ovf <= w_ovf_upd;
        end
    end

    // Result registers only change on close, so they hold through HOLD.
    assign dest_data  = r_dest_data;
    assign dest_count = r_dest_count;
    assign dest_ovf   = r_dest_ovf;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_accumulator
// Description : Self-checking bench for product_accumulator. Three instances:
//               default parameters, ACC_W=33 (overflow), BLK_LEN=1.
//               Drivers push expected block results into per-instance queues;
//               a monitor pops and compares on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

    typedef struct {
        logic [39:0] data;
        int          cnt;
        bit          ovf;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        sv    [3];
    logic [31:0] sd    [3];
    logic        fl    [3];
    logic        drdy  [3];
    logic        sr    [3];
    logic        dv    [3];
    logic [39:0] dd    [3];
    logic [3:0]  dc    [3];
    logic        dov   [3];

    logic [32:0] dd1;
    logic [39:0] dd0;
    logic [39:0] dd2;
    logic [3:0]  dc0;
    logic [3:0]  dc1;
    logic [0:0]  dc2;

    int   checks = 0;
    int   errors = 0;

    exp_t sb    [3][$];
    int   prods [3][$];
    int   aw    [3] = '{40, 33, 40};
    int   bl    [3] = '{8, 8, 1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(32), .ACC_W(40), .BLK_LEN(8)) u_dut0 (
        .clk(clk), .reset(reset),
        .src_valid(sv[0]), .src_ready(sr[0]), .src_data(sd[0]), .flush(fl[0]),
        .dest_valid(dv[0]), .dest_ready(drdy[0]),
        .dest_data(dd0), .dest_count(dc0), .dest_ovf(dov[0])
    );

    product_accumulator #(.PROD_W(32), .ACC_W(33), .BLK_LEN(8)) u_dut1 (
        .clk(clk), .reset(reset),
        .src_valid(sv[1]), .src_ready(sr[1]), .src_data(sd[1]), .flush(fl[1]),
        .dest_valid(dv[1]), .dest_ready(drdy[1]),
        .dest_data(dd1), .dest_count(dc1), .dest_ovf(dov[1])
    );

    product_accumulator #(.PROD_W(32), .ACC_W(40), .BLK_LEN(1)) u_dut2 (
        .clk(clk), .reset(reset),
        .src_valid(sv[2]), .src_ready(sr[2]), .src_data(sd[2]), .flush(fl[2]),
        .dest_valid(dv[2]), .dest_ready(drdy[2]),
        .dest_data(dd2), .dest_count(dc2), .dest_ovf(dov[2])
    );

    assign dd[0] = dd0;
    assign dd[1] = {7'b0, dd1};
    assign dd[2] = dd2;
    assign dc[0] = dc0;
    assign dc[1] = dc1;
    assign dc[2] = {3'b0, dc2};

    // ------------------------------------------------------------------------
    // Reference model: a block is the list of accepted products; the result
    // is their running sum wrapped into the signed ACC_W range, with the flag
    // set if any partial sum left that range.
    // ------------------------------------------------------------------------
    function automatic void model_close(int k);
        longint v   = 0;
        longint lim = longint'(1) <<< (aw[k] - 1);
        bit     o   = 1'b0;
        exp_t   e;
        for (int i = 0; i < prods[k].size(); i++) begin
            v = v + longint'(prods[k][i]);
            if (v >= lim) begin
                v = v - 2 * lim;
                o = 1'b1;
            end else if (v < -lim) begin
                v = v + 2 * lim;
                o = 1'b1;
            end
        end
        e.data = 40'(v & (2 * lim - 1));
        e.cnt  = prods[k].size();
        e.ovf  = o;
        sb[k].push_back(e);
        prods[k].delete();
    endfunction

    function automatic void model_accept(int k, logic [31:0] v, bit f);
        prods[k].push_back(int'($signed(v)));
        if (prods[k].size() == bl[k] || f) begin
            model_close(k);
        end
    endfunction

    task automatic chk(string name, logic [39:0] act, logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one product (optionally with flush) until accepted.
    // Entered and left at posedge+1.
    task automatic send(int k, logic [31:0] v, bit f, bit bp);
        sv[k] = 1'b1;
        sd[k] = v;
        fl[k] = f;
        for (int c = 0; c < 200; c++) begin
            if (bp) drdy[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (sr[k]) begin
                model_accept(k, v, f);
                @(posedge clk);
                #1;
                sv[k] = 1'b0;
                fl[k] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout dut%0d: src_ready stayed 0 for 200 cycles", k);
        sv[k] = 1'b0;
        fl[k] = 1'b0;
    endtask

    // Pulse flush alone for one cycle.
    task automatic flush_only(int k);
        fl[k] = 1'b1;
        @(negedge clk);
        if (sr[k] && prods[k].size() > 0) model_close(k);
        @(posedge clk);
        #1;
        fl[k] = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Monitor: each output handshake consumes one expected result.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                if (dv[k] && drdy[k]) begin
                    checks++;
                    if (sb[k].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result dut%0d: got data=%h count=%0d, expected none",
                                 k, dd[k], dc[k]);
                    end else begin
                        exp_t e;
                        e = sb[k].pop_front();
                        if (dd[k] !== e.data || dc[k] !== 4'(e.cnt) || dov[k] !== e.ovf) begin
                            errors++;
                            $display("FAIL result dut%0d: got data=%h count=%0d ovf=%0d, expected data=%h count=%0d ovf=%0d",
                                     k, dd[k], dc[k], dov[k], e.data, e.cnt, e.ovf);
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sv[k] = 1'b0; sd[k] = '0; fl[k] = 1'b0; drdy[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dest_valid", 40'(dv[0]), 40'd0);
        chk("reset_src_ready",  40'(sr[0]), 40'd1);
        chk("reset_dest_data",  dd[0], 40'd0);
        chk("reset_dest_count", 40'(dc[0]), 40'd0);
        chk("reset_dest_ovf",   40'(dov[0]), 40'd0);
        reset = 1'b0;

        // 1..8 back to back, dest_ready high.
        for (int i = 1; i <= 8; i++) send(0, 32'(i), 1'b0, 1'b0);
        @(negedge clk);
        chk("blk8_valid",     40'(dv[0]), 40'd1);
        chk("blk8_src_ready", 40'(sr[0]), 40'd0);
        chk("blk8_data",      dd[0], 40'd36);
        chk("blk8_count",     40'(dc[0]), 40'd8);
        @(negedge clk);
        chk("blk8_src_ready_next", 40'(sr[0]), 40'd1);
        chk("blk8_valid_next",     40'(dv[0]), 40'd0);
        @(posedge clk);
        #1;

        // Eight -5 with backpressure for 5 cycles.
        drdy[0] = 1'b0;
        for (int i = 0; i < 8; i++) send(0, 32'hFFFF_FFFB, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid",     40'(dv[0]), 40'd1);
            chk("bp_src_ready", 40'(sr[0]), 40'd0);
            chk("bp_data",      dd[0], 40'hFF_FFFF_FFD8);
        end
        @(posedge clk);
        #1;
        drdy[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_released_valid", 40'(dv[0]), 40'd0);
        chk("bp_released_ready", 40'(sr[0]), 40'd1);
        @(posedge clk);
        #1;

        // 3, 4, 5 then flush alone; then a flush on an empty block.
        send(0, 32'd3, 1'b0, 1'b0);
        send(0, 32'd4, 1'b0, 1'b0);
        send(0, 32'd5, 1'b0, 1'b0);
        flush_only(0);
        @(negedge clk);
        chk("flush_valid", 40'(dv[0]), 40'd1);
        chk("flush_data",  dd[0], 40'd12);
        chk("flush_count", 40'(dc[0]), 40'd3);
        @(posedge clk);
        #1;
        flush_only(0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("empty_flush_noop", 40'(dv[0]), 40'd0);
        end
        @(posedge clk);
        #1;

        // Flush in the same cycle as an accept.
        send(0, 32'd10, 1'b0, 1'b0);
        send(0, 32'd20, 1'b0, 1'b0);
        send(0, 32'd30, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_accept_data",  dd[0], 40'd60);
        chk("flush_accept_count", 40'(dc[0]), 40'd3);
        @(posedge clk);
        #1;

        // ACC_W=33 overflow, then a clean block.
        for (int i = 0; i < 3; i++) send(1, 32'h7FFF_FFFF, 1'b0, 1'b0);
        flush_only(1);
        @(negedge clk);
        chk("ovf_flag",  40'(dov[1]), 40'd1);
        chk("ovf_count", 40'(dc[1]), 40'd3);
        @(posedge clk);
        #1;
        send(1, 32'd1, 1'b0, 1'b0);
        send(1, 32'd2, 1'b1, 1'b0);
        @(negedge clk);
        chk("ovf_cleared", 40'(dov[1]), 40'd0);
        chk("ovf_next_data", dd[1], 40'd3);
        @(posedge clk);
        #1;

        // Reset mid-block discards the partial sum.
        for (int i = 0; i < 4; i++) send(0, 32'(100 + i), 1'b0, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            prods[k].delete();
            sb[k].delete();
        end
        #1;
        chk("midreset_valid", 40'(dv[0]), 40'd0);
        chk("midreset_ready", 40'(sr[0]), 40'd1);
        chk("midreset_data",  dd[0], 40'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) send(0, 32'(i), 1'b0, 1'b0);
        @(negedge clk);
        chk("post_reset_data",  dd[0], 40'd36);
        chk("post_reset_count", 40'(dc[0]), 40'd8);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and flushes.
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [31:0] v;
            r = int'($urandom_range(0, 15));
            if (r < 4) v = $urandom;
            else       v = 32'(int'($urandom_range(0, 2000)) - 1000);
            if (r == 15) flush_only(0);
            else         send(0, v, (r == 14), 1'b1);
        end

        // BLK_LEN=1: every accept closes a block of one.
        for (int i = 0; i < 30; i++) begin
            send(2, $urandom, ($urandom_range(0, 3) == 0), 1'b1);
        end

        // Drain outstanding results.
        for (int k = 0; k < 3; k++) drdy[k] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sb[k].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d: got %0d results pending, expected 0", k, sb[k].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
